// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types and constants for the tank game datapath
//
// Purpose: bullet FSM state type, wall nibble bit indices and the
// coordinate, velocity and maze address widths used by bullet_motion.
// Ports: none (package).
package tank_pkg;

  localparam int COORD_W  = 10;
  localparam int VEL_W    = 4;
  localparam int MAZE_AW  = 8;
  localparam int LIFE_W   = 10;
  localparam int BOUNCE_W = 8;

  // Bit positions inside a maze wall nibble.
  localparam int WALL_TOP    = 0;
  localparam int WALL_LEFT   = 1;
  localparam int WALL_BOTTOM = 2;
  localparam int WALL_RIGHT  = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_PROBE = 3'd2,
    S_FETCH = 3'd3,
    S_EVAL  = 3'd4
  } bullet_state_t;

endpackage

// File: rtl/bullet_motion.sv
// rtl/bullet_motion.sv - per-bullet motion sequencer ahead of the wall checker
//
// Purpose: holds one bullet's position, velocity, lifetime and bounce count.
// Each accepted frame tick probes the candidate next position through the
// external collision checker, reads the wall nibble from maze RAM, reflects
// per axis on collision and commits the move. Retires on lifetime expiry,
// bounce limit or kill.
// Ports:
//   Clk, Reset_n             clock, asynchronous active-low reset
//   frame_tick               one pulse per video frame
//   fire, fire_x/y, fire_dx/dy  launch request, position, signed velocity
//   kill                     retire a live bullet
//   chk_x/y (out)            probe position for the checker
//   chk_addr, chk_pos (in)   maze byte address and nibble select from checker
//   chk_wall (out)           wall nibble returned to the checker
//   chk_xcol, chk_ycol (in)  per-axis collision flags from checker
//   mem_addr (out), mem_data (in)  synchronous maze RAM, 1-cycle read
//   bx, by, active, busy     committed position and status
module bullet_motion
  import tank_pkg::*;
#(
  parameter int LIFETIME   = 600,
  parameter int MAX_BOUNCE = 15
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               fire,
  input  logic [COORD_W-1:0] fire_x,
  input  logic [COORD_W-1:0] fire_y,
  input  logic [VEL_W-1:0]   fire_dx,
  input  logic [VEL_W-1:0]   fire_dy,
  input  logic               kill,
  output logic [COORD_W-1:0] chk_x,
  output logic [COORD_W-1:0] chk_y,
  input  logic [MAZE_AW-1:0] chk_addr,
  input  logic               chk_pos,
  output logic [3:0]         chk_wall,
  input  logic               chk_xcol,
  input  logic               chk_ycol,
  output logic [MAZE_AW-1:0] mem_addr,
  input  logic [7:0]         mem_data,
  output logic [COORD_W-1:0] bx,
  output logic [COORD_W-1:0] by,
  output logic               active,
  output logic               busy
);

  localparam logic [LIFE_W-1:0]   LIFE_INIT = LIFE_W'(LIFETIME);
  localparam logic [BOUNCE_W-1:0] BOUNCE_LIM = BOUNCE_W'(MAX_BOUNCE);
  localparam logic                BOUNCE_EN = (MAX_BOUNCE != 0);

  bullet_state_t       state;
  logic [VEL_W-1:0]    dx, dy;
  logic [LIFE_W-1:0]   life;
  logic [BOUNCE_W-1:0] bounce;
  logic                pos_q;
  logic [3:0]          wall_q;

  logic [3:0]          nibble;
  logic                hit;
  logic [LIFE_W-1:0]   life_nxt;
  logic [BOUNCE_W-1:0] bounce_nxt;
  logic                retire;

  // Wall nibble is combinational from RAM data during EVAL so the checker
  // sees it in the same cycle it drives xcol/ycol; otherwise hold last value.
  assign nibble   = pos_q ? mem_data[7:4] : mem_data[3:0];
  assign chk_wall = (state == S_EVAL) ? nibble : wall_q;
  assign active   = (state != S_IDLE);
  assign busy     = (state != S_IDLE);

  always_comb begin
    hit        = chk_xcol | chk_ycol;
    life_nxt   = life - LIFE_W'(1);
    bounce_nxt = bounce;
    if (hit && (bounce != {BOUNCE_W{1'b1}})) begin
      bounce_nxt = bounce + BOUNCE_W'(1);
    end
    retire = (life_nxt == '0) || (BOUNCE_EN && (bounce_nxt >= BOUNCE_LIM));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      bx       <= '0;
      by       <= '0;
      dx       <= '0;
      dy       <= '0;
      life     <= '0;
      bounce   <= '0;
      chk_x    <= '0;
      chk_y    <= '0;
      mem_addr <= '0;
      pos_q    <= 1'b0;
      wall_q   <= '0;
    end else if (kill && (state != S_IDLE)) begin
      // Kill overrides any commit or tick in flight; position is left as-is.
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire) begin
            bx     <= fire_x;
            by     <= fire_y;
            dx     <= fire_dx;
            dy     <= fire_dy;
            life   <= LIFE_INIT;
            bounce <= '0;
            state  <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (frame_tick) begin
            chk_x <= bx + {{(COORD_W-VEL_W){dx[VEL_W-1]}}, dx};
            chk_y <= by + {{(COORD_W-VEL_W){dy[VEL_W-1]}}, dy};
            state <= S_PROBE;
          end
        end
        S_PROBE: begin
          mem_addr <= chk_addr;
          pos_q    <= chk_pos;
          state    <= S_FETCH;
        end
        S_FETCH: begin
          state <= S_EVAL;
        end
        S_EVAL: begin
          wall_q <= nibble;
          if (chk_xcol) dx <= -dx;
          else          bx <= chk_x;
          if (chk_ycol) dy <= -dy;
          else          by <= chk_y;
          bounce <= bounce_nxt;
          life   <= life_nxt;
          state  <= retire ? S_IDLE : S_ARMED;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_motion.sv
// tb/tb_bullet_motion.sv - self-checking bench for bullet_motion
module tb_bullet_motion;

  localparam int LIFE = 3;
  localparam int MAXB = 2;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] fire_x = '0, fire_y = '0;
  logic [3:0] fire_dx = '0, fire_dy = '0;
  logic       kill = 1'b0;
  logic [9:0] chk_x, chk_y;
  logic [7:0] chk_addr = '0;
  logic       chk_pos = 1'b0;
  logic [3:0] chk_wall;
  logic       chk_xcol = 1'b0, chk_ycol = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic [9:0] bx, by;
  logic       active, busy;

  logic [7:0] maze [0:255];

  int total = 0;
  int bad = 0;

  // Reference model of one bullet, in plain integers.
  int m_bx, m_by, m_dx, m_dy, m_life, m_bounce;
  bit m_active;

  // Values captured by do_tick.
  logic [9:0] probe_x, probe_y, eval_bx, eval_by;
  logic [3:0] eval_wall;
  int  exp_px, exp_py, pre_bx, pre_by;
  bit  pre_active;

  bullet_motion #(.LIFETIME(LIFE), .MAX_BOUNCE(MAXB)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .fire(fire),
    .fire_x(fire_x), .fire_y(fire_y), .fire_dx(fire_dx), .fire_dy(fire_dy),
    .kill(kill), .chk_x(chk_x), .chk_y(chk_y), .chk_addr(chk_addr),
    .chk_pos(chk_pos), .chk_wall(chk_wall), .chk_xcol(chk_xcol),
    .chk_ycol(chk_ycol), .mem_addr(mem_addr), .mem_data(mem_data),
    .bx(bx), .by(by), .active(active), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Synchronous maze RAM: data valid one cycle after the address.
  always @(posedge Clk) mem_data <= maze[mem_addr];

  function automatic int neg4(input int v);
    return (v == -8) ? -8 : -v;
  endfunction

  function automatic void model_fire(input int x, input int y, input int vx, input int vy);
    if (!m_active) begin
      m_bx = x; m_by = y; m_dx = vx; m_dy = vy;
      m_life = LIFE; m_bounce = 0; m_active = 1;
    end
  endfunction

  function automatic void model_tick(input bit xc, input bit yc);
    if (!m_active) return;
    if (xc) m_dx = neg4(m_dx); else m_bx = (m_bx + m_dx) & 1023;
    if (yc) m_dy = neg4(m_dy); else m_by = (m_by + m_dy) & 1023;
    if (xc || yc) m_bounce = m_bounce + 1;
    m_life = m_life - 1;
    if (m_life == 0 || (MAXB != 0 && m_bounce >= MAXB)) m_active = 0;
  endfunction

  task automatic do_fire(input int x, input int y, input int vx, input int vy);
    fire_x = 10'(x); fire_y = 10'(y); fire_dx = 4'(vx); fire_dy = 4'(vy);
    fire = 1'b1;
    @(negedge Clk);
    fire = 1'b0;
    model_fire(x, y, vx, vy);
  endtask

  task automatic do_kill();
    kill = 1'b1;
    @(negedge Clk);
    kill = 1'b0;
    m_active = 0;
  endtask

  task automatic do_tick(input bit xc, input bit yc, input bit pos,
                         input logic [7:0] addr, input logic [7:0] mv);
    chk_xcol = xc; chk_ycol = yc; chk_pos = pos; chk_addr = addr;
    maze[addr] = mv;
    exp_px = (m_bx + m_dx) & 1023;
    exp_py = (m_by + m_dy) & 1023;
    pre_bx = m_bx; pre_by = m_by; pre_active = m_active;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    probe_x = chk_x; probe_y = chk_y;
    @(negedge Clk);
    @(negedge Clk);
    eval_wall = chk_wall; eval_bx = bx; eval_by = by;
    @(negedge Clk);
    model_tick(xc, yc);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) maze[i] = 8'h00;
    m_active = 0; m_bx = 0; m_by = 0; m_dx = 0; m_dy = 0;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    total++;
    if ({bx, by, chk_x, chk_y, mem_addr, chk_wall, active, busy} !== '0) begin
      bad++;
      $display("FAIL reset_values: got bx=%0d by=%0d cx=%0d cy=%0d ma=%0h w=%0h a=%0b b=%0b, want all 0",
               bx, by, chk_x, chk_y, mem_addr, chk_wall, active, busy);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_free_flight();
    do_fire(100, 100, 2, 0);
    total++;
    if (active !== 1'b1) begin bad++; $display("FAIL ff_armed: active=%b want 1", active); end
    do_tick(0, 0, 0, 8'h11, 8'h00);
    total++;
    if (probe_x !== 10'd102 || probe_y !== 10'd100) begin
      bad++; $display("FAIL ff_probe: got (%0d,%0d) want (102,100)", probe_x, probe_y);
    end
    total++;
    if (eval_bx !== 10'd100) begin bad++; $display("FAIL ff_early: bx=%0d at T+3 want 100", eval_bx); end
    total++;
    if (bx !== 10'd102 || by !== 10'd100 || active !== 1'b1) begin
      bad++; $display("FAIL ff_commit: got (%0d,%0d,%b) want (102,100,1)", bx, by, active);
    end
    do_kill();
  endtask

  task automatic test_right_wall();
    do_fire(120, 50, 3, 0);
    do_tick(1, 0, 0, 8'h22, 8'h08);
    total++;
    if (eval_wall !== 4'h8) begin bad++; $display("FAIL rw_wall: got %h want 8", eval_wall); end
    total++;
    if (bx !== 10'd120 || by !== 10'd50 || active !== 1'b1) begin
      bad++; $display("FAIL rw_bounce: got (%0d,%0d,%b) want (120,50,1)", bx, by, active);
    end
    do_tick(0, 0, 0, 8'h22, 8'h00);
    total++;
    if (bx !== 10'd117) begin bad++; $display("FAIL rw_reflect: bx=%0d want 117", bx); end
    do_kill();
  endtask

  task automatic test_corner();
    do_fire(200, 200, 2, -1);
    do_tick(1, 1, 1, 8'h33, 8'hC0);
    total++;
    if (eval_wall !== 4'hC) begin bad++; $display("FAIL corner_wall: got %h want c", eval_wall); end
    total++;
    if (bx !== 10'd200 || by !== 10'd200 || active !== 1'b1) begin
      bad++; $display("FAIL corner_hold: got (%0d,%0d,%b) want (200,200,1)", bx, by, active);
    end
    // Second bounce event reaches the limit of 2: retire, y moves by +1.
    do_tick(1, 0, 0, 8'h33, 8'h00);
    total++;
    if (bx !== 10'd200 || by !== 10'd201 || active !== 1'b0) begin
      bad++; $display("FAIL corner_limit: got (%0d,%0d,%b) want (200,201,0)", bx, by, active);
    end
  endtask

  task automatic test_neg8();
    do_fire(500, 500, -8, 0);
    do_tick(1, 0, 0, 8'h44, 8'h00);
    do_tick(0, 0, 0, 8'h44, 8'h00);
    total++;
    if (bx !== 10'd492) begin bad++; $display("FAIL neg8: bx=%0d want 492", bx); end
    do_kill();
  endtask

  task automatic test_lifetime();
    logic [9:0] sx;
    logic [7:0] sa;
    do_fire(10, 10, 1, 1);
    do_tick(0, 0, 0, 8'h01, 8'h00);
    do_tick(0, 0, 0, 8'h02, 8'h00);
    total++;
    if (active !== 1'b1) begin bad++; $display("FAIL life_2: active=%b want 1", active); end
    do_tick(0, 0, 0, 8'h03, 8'h00);
    total++;
    if (active !== 1'b0 || busy !== 1'b0 || bx !== 10'd13) begin
      bad++; $display("FAIL life_3: got a=%b b=%b bx=%0d want 0 0 13", active, busy, bx);
    end
    sx = chk_x; sa = mem_addr;
    do_tick(0, 0, 0, 8'h77, 8'h00);
    total++;
    if (chk_x !== sx || mem_addr !== sa) begin
      bad++; $display("FAIL life_4: cx=%0d ma=%h want %0d %h", chk_x, mem_addr, sx, sa);
    end
  endtask

  task automatic test_kill_fetch();
    do_fire(300, 300, 1, 1);
    do_tick(0, 0, 0, 8'h05, 8'h00);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    @(negedge Clk);
    kill = 1'b1;
    @(negedge Clk);
    kill = 1'b0;
    m_active = 0;
    total++;
    if (active !== 1'b0 || busy !== 1'b0 || bx !== 10'd301 || by !== 10'd301) begin
      bad++; $display("FAIL kill_fetch: got a=%b (%0d,%0d) want 0 (301,301)", active, bx, by);
    end
    repeat (3) @(negedge Clk);
    total++;
    if (bx !== 10'd301 || busy !== 1'b0) begin
      bad++; $display("FAIL kill_hold: bx=%0d busy=%b want 301 0", bx, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_fire(400, 400, 1, 0);
    do_fire(5, 5, 3, 3);
    total++;
    if (bx !== 10'd400 || by !== 10'd400) begin
      bad++; $display("FAIL fire_armed: got (%0d,%0d) want (400,400)", bx, by);
    end
    // Second tick lands in PROBE and must be dropped.
    frame_tick = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    frame_tick = 1'b0;
    repeat (8) @(negedge Clk);
    total++;
    if (bx !== 10'd401 || active !== 1'b1) begin
      bad++; $display("FAIL tick_drop: bx=%0d a=%b want 401 1", bx, active);
    end
    do_kill();
    // fire with tick in IDLE launches only.
    fire_x = 10'd77; fire_y = 10'd88; fire_dx = 4'd1; fire_dy = 4'd1;
    fire = 1'b1; frame_tick = 1'b1;
    @(negedge Clk);
    fire = 1'b0; frame_tick = 1'b0;
    repeat (5) @(negedge Clk);
    total++;
    if (bx !== 10'd77 || by !== 10'd88 || busy !== 1'b1) begin
      bad++; $display("FAIL fire_tick: got (%0d,%0d,%b) want (77,88,1)", bx, by, busy);
    end
    // fire with kill in IDLE: fire wins. Bullet is live, so kill first.
    do_kill();
    fire_x = 10'd33; fire_y = 10'd44;
    fire = 1'b1; kill = 1'b1;
    @(negedge Clk);
    fire = 1'b0; kill = 1'b0;
    total++;
    if (active !== 1'b1 || bx !== 10'd33) begin
      bad++; $display("FAIL fire_kill: a=%b bx=%0d want 1 33", active, bx);
    end
    do_kill();
  endtask

  task automatic test_random();
    int x, y, vx, vy, n;
    bit xc, yc, p;
    logic [7:0] a, mv;
    for (int l = 0; l < 25; l++) begin
      x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023));
      vx = int'($urandom_range(0, 14)) - 7; vy = int'($urandom_range(0, 14)) - 7;
      do_fire(x, y, vx, vy);
      n = int'($urandom_range(1, 4));
      for (int t = 0; t < n; t++) begin
        if ($urandom_range(0, 9) == 0) do_kill();
        xc = ($urandom_range(0, 2) == 0); yc = ($urandom_range(0, 2) == 0);
        p = 1'($urandom_range(0, 1)); a = 8'($urandom_range(0, 255)); mv = 8'($urandom);
        do_tick(xc, yc, p, a, mv);
        if (pre_active) begin
          total++;
          if (probe_x !== 10'(exp_px) || probe_y !== 10'(exp_py) ||
              eval_wall !== (p ? mv[7:4] : mv[3:0]) ||
              eval_bx !== 10'(pre_bx) || eval_by !== 10'(pre_by)) begin
            bad++;
            $display("FAIL rnd_probe l=%0d t=%0d: probe (%0d,%0d) wall %h pre (%0d,%0d) want (%0d,%0d) %h (%0d,%0d)",
                     l, t, probe_x, probe_y, eval_wall, eval_bx, eval_by, exp_px, exp_py,
                     (p ? mv[7:4] : mv[3:0]), pre_bx, pre_by);
          end
        end
        total++;
        if (bx !== 10'(m_bx) || by !== 10'(m_by) || active !== m_active) begin
          bad++;
          $display("FAIL rnd_commit l=%0d t=%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                   l, t, bx, by, active, m_bx, m_by, m_active);
        end
      end
      if (m_active) do_kill();
    end
  endtask

  task automatic test_reset_mid();
    do_fire(50, 60, 1, 1);
    chk_addr = 8'h5A; chk_xcol = 1'b0; chk_ycol = 1'b0;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    m_active = 0;
    total++;
    if ({bx, by, chk_x, chk_y, mem_addr, chk_wall, active, busy} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got bx=%0d by=%0d cx=%0d cy=%0d ma=%0h w=%0h a=%0b b=%0b, want all 0",
               bx, by, chk_x, chk_y, mem_addr, chk_wall, active, busy);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    do_fire(10, 20, 0, 0);
    total++;
    if (bx !== 10'd10 || by !== 10'd20 || active !== 1'b1) begin
      bad++; $display("FAIL reset_refire: got (%0d,%0d,%b) want (10,20,1)", bx, by, active);
    end
  endtask

  initial begin
    test_reset();
    test_free_flight();
    test_right_wall();
    test_corner();
    test_neg8();
    test_lifetime();
    test_kill_fetch();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bullet_motion.md
Name: bullet_motion

Overview:
- Per-bullet motion sequencer that sits directly upstream of the wall-collision checker.
- Holds bullet position, velocity and lifetime.
- On each frame tick it presents the candidate next position to the checker, fetches that cell's wall nibble from the synchronous maze RAM, and returns it to the checker.
- Applies the returned xcol/ycol as per-axis reflections, then commits the new position; retires the bullet on lifetime expiry, bounce limit or kill.

Parameters:
- LIFETIME, 600, frames a bullet lives (10 s at 60 Hz); range 1..1023.
- MAX_BOUNCE, 15, reflection events after which the bullet retires; 0 means unlimited.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  single-cycle pulse, once per video frame
- fire  in  1  single-cycle launch request
- fire_x, fire_y  in  10  launch position (pixels, unsigned)
- fire_dx, fire_dy  in  4  launch velocity (signed, pixels/frame)
- kill  in  1  single-cycle retire request (tank hit)
- chk_x, chk_y  out  10  probe position driven to the collision checker
- chk_addr  in  8  maze byte address returned by the checker
- chk_pos  in  1  nibble select returned by the checker
- chk_wall  out  4  wall nibble driven to the checker; bit0 top, bit1 left, bit2 bottom, bit3 right
- chk_xcol, chk_ycol  in  1  per-axis collision flags from the checker
- mem_addr  out  8  maze RAM read address
- mem_data  in  8  maze RAM data, valid 1 cycle after mem_addr
- bx, by  out  10  committed bullet position
- active  out  1  bullet alive
- busy  out  1  high when not IDLE

Behaviour:
- Reset (async, Reset_n=0): state IDLE. bx, by, chk_x, chk_y, mem_addr, chk_wall, velocity, counters all 0. active=0, busy=0.
- States: IDLE, ARMED, PROBE, FETCH, EVAL.
- IDLE: on fire, load bx/by from fire_x/y and dx/dy from fire_dx/dy; life counter := LIFETIME; bounce counter := 0. Go to ARMED with active=1. fire outside IDLE is ignored.
- ARMED: on frame_tick, register chk_x = bx + sext(dx) and chk_y = by + sext(dy), arithmetic modulo 1024. Go to PROBE.
- Ticks in PROBE/FETCH/EVAL are dropped; no queuing.
- PROBE: register mem_addr := chk_addr and pos_q := chk_pos. Go to FETCH.
- FETCH: wait one cycle for RAM data. Go to EVAL.
- EVAL: chk_wall = pos_q ? mem_data[7:4] : mem_data[3:0] (combinational from mem_data). Sample chk_xcol/chk_ycol this cycle.
  - If xcol: dx := -dx and bx unchanged; else bx := chk_x.
  - If ycol: dy := -dy and by unchanged; else by := chk_y.
  - Bounce counter += 1 if xcol|ycol (one event even if both axes collide; saturating).
  - Life counter -= 1.
  - If the life counter reaches 0, or (MAX_BOUNCE≠0 and the bounce counter reaches MAX_BOUNCE): go to IDLE, active=0. Else go to ARMED.
- Latency: frame_tick in cycle T produces updated bx/by/active visible in cycle T+4.
- chk_wall holds its last value outside EVAL.
- dx = -8 negated stays -8. This is documented; the firing logic must never issue -8.
- kill: in any non-IDLE state, next state is IDLE with active=0. bx/by hold their last committed value. kill beats a concurrent EVAL commit and a concurrent tick.
- fire and kill together in IDLE: fire wins (kill targets a live bullet only).
- fire and frame_tick together in IDLE: launch only; the first move uses the next tick.
- Reset asserted mid-sequence: immediate return to reset values. No RAM read is completed.

Decomposition:
- Shared package tank_pkg:
  - state enum bullet_state_t.
  - wall bit index constants WALL_TOP=0, WALL_LEFT=1, WALL_BOTTOM=2, WALL_RIGHT=3.
  - COORD_W=10, VEL_W=4, MAZE_AW=8.
- No sub-module. The collision checker stays an external sibling, wired through the chk_* ports at the top level.

Test Plan:
- Free flight: fire (100,100), dx=+2, dy=0, mem_data=0x00, checker flags 0, tick -> bx=102, by=100 exactly 4 cycles after the tick; active=1.
- Right-wall bounce: bx=120, dx=+3, chk_pos=0, mem_data=0x08, checker drives xcol=1 -> dx=-3, bx stays 120. Next tick -> bx=117.
- Corner: chk_pos=1, mem_data=0xC0, checker drives xcol=ycol=1 -> both velocities negated, position unchanged, bounce count +1 (not +2).
- Lifetime: LIFETIME=3, three ticks -> active=0 at EVAL of third tick; a fourth tick causes no chk_x/mem_addr change.
- Kill/collisions of events: kill during FETCH -> IDLE next cycle, bx/by unchanged. fire while ARMED -> ignored. tick during PROBE -> dropped; exactly one move per accepted tick.
- Reset: Reset_n low during EVAL -> all outputs 0 immediately. After release, fire at (10,20) -> bx=10, by=20.
